alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL take these parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.
- INST_BYTES, 4, link increment for jal/jalr.
- CNT_W, 16, hazard counter width.

REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset.
- in_valid  in  1  decode-side operand bundle valid.
- in_ready  out  1  stage accepts the bundle.
- in_pc  in  XLEN  instruction PC.
- in_rs1_addr, in_rs2_addr  in  RA_W  source register indices.
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data.
- in_imm  in  XLEN  sign-extended immediate.
- in_a_sel  in  2  operand A select.
- in_b_sel  in  2  operand B select.
- in_uses_rs2  in  1  rs2 consumed (branch/store/R-type).
- exm_wr_en  in  1  EX/MEM writes rd.
- exm_is_load  in  1  EX/MEM holds a load.
- exm_rd  in  RA_W  EX/MEM destination.
- exm_data  in  XLEN  EX/MEM result.
- wb_wr_en  in  1  MEM/WB writes rd.
- wb_rd  in  RA_W  MEM/WB destination.
- wb_data  in  XLEN  MEM/WB result.
- flush  in  1  kill the registered bundle (branch taken).
- out_valid  out  1  registered bundle valid.
- out_ready  in  1  ALU accepts the bundle.
- out_a, out_b  out  XLEN  ALU operands.
- out_rs2  out  XLEN  forwarded rs2 (store data / branch compare).
- hazard_cnt  out  CNT_W  load-use stall cycles.

REQ-003 Clock is clk; reset is rst_n, asynchronous, active-low; single clock domain.

Function
REQ-004 Operand A select SHALL be: 0 forwarded rs1, 1 in_pc (jal/jalr/auipc), 2 zero (lui), 3 zero.
REQ-005 Operand B select SHALL be: 0 forwarded rs2, 1 in_imm, 2 INST_BYTES (link), 3 zero.
REQ-006 Forwarded rsN SHALL be, in priority order:
- exm_data if exm_wr_en, exm_rd==rsN and rsN!=0;
- else wb_data if wb_wr_en, wb_rd==rsN and rsN!=0;
- else in_rsN_data.
REQ-007 Register index 0 SHALL never forward; its data SHALL read as in_rsN_data.
REQ-008 hazard SHALL assert when all of the following hold: in_valid, exm_wr_en, exm_is_load, exm_rd!=0, and (exm_rd==rs1 with a_sel==0, or exm_rd==rs2 with in_uses_rs2).
REQ-009 in_ready SHALL equal (!out_valid || out_ready) && !hazard && !flush.
REQ-010 On in_valid && in_ready, the block SHALL register out_a, out_b, out_rs2 and set out_valid at the next edge (latency 1).
REQ-011 When out_valid && out_ready and no new capture occurs, out_valid SHALL clear at the next edge.
REQ-012 When out_valid && !out_ready, out_a, out_b, out_rs2 and out_valid SHALL hold stable.
REQ-013 flush SHALL clear out_valid at the next edge, overriding capture in the same cycle.
REQ-014 During a hazard cycle no capture SHALL occur. The next cycle, with the load in MEM/WB, forwarding SHALL take wb_data.
REQ-015 hazard_cnt SHALL increment by 1 on each cycle hazard is high and saturate at all-ones.
REQ-016 All XLEN arithmetic SHALL be unsigned bit-copy; INST_BYTES SHALL be zero-extended to XLEN.

Reset
REQ-017 While rst_n is low, the block SHALL hold out_valid=0, out_a=0, out_b=0, out_rs2=0 and hazard_cnt=0.
REQ-018 Reset asserted mid-stall or mid-backpressure SHALL discard the held bundle; there SHALL be no capture on the first edge after release unless in_ready is met.

Structure
REQ-019 The shared package alu_pkg SHALL hold the A_SEL/B_SEL encodings and the XLEN and RA_W defaults.
REQ-020 Per-operand forwarding SHALL be the sub-module fwd_unit, instantiated twice (rs1, rs2).

Verification
REQ-021 Bench: rs1=5, exm_wr_en=1, exm_rd=5, exm_data=0xAAAA, wb_rd=5, wb_data=0xBBBB, a_sel=0 -> out_a=0xAAAA after 1 cycle.
REQ-022 Bench: rs1=0, exm_rd=0, exm_data=0x1234, in_rs1_data=0 -> out_a=0; jal with a_sel=1, b_sel=2, pc=0x100 -> out_a=0x100, out_b=4.
REQ-023 Bench: exm load to rd=7, next instr rs2=7 with uses_rs2=1 -> in_ready=0 for 1 cycle and hazard_cnt=1. Next cycle wb_rd=7, wb_data=0x55 -> out_rs2=0x55.
REQ-024 Bench: out_ready=0 for 3 cycles with in_valid=1 -> outputs hold, in_ready=0. On out_ready=1, the new bundle appears on the next edge.
REQ-025 Bench: flush with in_valid=1 -> out_valid=0 next edge; rst_n pulsed low during backpressure -> all outputs 0 immediately.
REQ-026 Bench: force hazard for 2^CNT_W+3 cycles (CNT_W=4 build) -> hazard_cnt holds at 15.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage: operand-select encodings
// and datapath width defaults.
package alu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 5;

    // Operand A sources.
    typedef enum logic [1:0] {
        A_SEL_RS1   = 2'd0,
        A_SEL_PC    = 2'd1,
        A_SEL_ZERO  = 2'd2,
        A_SEL_ZERO3 = 2'd3
    } a_sel_e;

    // Operand B sources.
    typedef enum logic [1:0] {
        B_SEL_RS2  = 2'd0,
        B_SEL_IMM  = 2'd1,
        B_SEL_LINK = 2'd2,
        B_SEL_ZERO = 2'd3
    } b_sel_e;

endpackage

// File: rtl/fwd_unit.sv
// Single-operand bypass selector: picks the youngest in-flight producer of a
// source register, falling back to the register-file read data. x0 never
// forwards so it always reads as whatever the register file supplies.
import alu_pkg::*;

module fwd_unit #(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic [RA_W-1:0] rs_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic            exm_wr_en,
    input  logic [RA_W-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_data,
    input  logic            wb_wr_en,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_data
);

    logic rs_nonzero_s;

    assign rs_nonzero_s = (rs_addr != {RA_W{1'b0}});

    // EX/MEM has priority over MEM/WB because it holds the younger result.
    always_comb begin
        fwd_data = rs_data;
        if (exm_wr_en && rs_nonzero_s && (exm_rd == rs_addr)) begin
            fwd_data = exm_data;
        end else if (wb_wr_en && rs_nonzero_s && (wb_rd == rs_addr)) begin
            fwd_data = wb_data;
        end else begin
            fwd_data = rs_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage between decode and ALU: forwards rs1/rs2, muxes ALU operands,
// detects load-use hazards and holds a one-entry registered bundle with
// valid/ready handshaking, flush and a saturating stall counter.
import alu_pkg::*;

module alu_operand_stage #(
    parameter int XLEN       = XLEN_DEF,
    parameter int RA_W       = RA_W_DEF,
    parameter int INST_BYTES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [RA_W-1:0]  in_rs1_addr,
    input  logic [RA_W-1:0]  in_rs2_addr,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [1:0]       in_a_sel,
    input  logic [1:0]       in_b_sel,
    input  logic             in_uses_rs2,
    input  logic             exm_wr_en,
    input  logic             exm_is_load,
    input  logic [RA_W-1:0]  exm_rd,
    input  logic [XLEN-1:0]  exm_data,
    input  logic             wb_wr_en,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_a,
    output logic [XLEN-1:0]  out_b,
    output logic [XLEN-1:0]  out_rs2,
    output logic [CNT_W-1:0] hazard_cnt
);

    localparam logic [XLEN-1:0]  LINK_INC = XLEN'(INST_BYTES);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [XLEN-1:0]  rs1_fwd_s;
    logic [XLEN-1:0]  rs2_fwd_s;
    logic [XLEN-1:0]  a_s;
    logic [XLEN-1:0]  b_s;
    logic             hazard_s;
    logic             ready_s;
    logic             capture_s;

    logic             out_valid_r;
    logic [XLEN-1:0]  out_a_r;
    logic [XLEN-1:0]  out_b_r;
    logic [XLEN-1:0]  out_rs2_r;
    logic [CNT_W-1:0] hazard_cnt_r;

    fwd_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .rs_addr   (in_rs1_addr),
        .rs_data   (in_rs1_data),
        .exm_wr_en (exm_wr_en),
        .exm_rd    (exm_rd),
        .exm_data  (exm_data),
        .wb_wr_en  (wb_wr_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .fwd_data  (rs1_fwd_s)
    );

    fwd_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .rs_addr   (in_rs2_addr),
        .rs_data   (in_rs2_data),
        .exm_wr_en (exm_wr_en),
        .exm_rd    (exm_rd),
        .exm_data  (exm_data),
        .wb_wr_en  (wb_wr_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .fwd_data  (rs2_fwd_s)
    );

    // Operand A mux: rs1, PC for jal/jalr/auipc, zero for lui.
    always_comb begin
        a_s = {XLEN{1'b0}};
        case (in_a_sel)
            A_SEL_RS1:   a_s = rs1_fwd_s;
            A_SEL_PC:    a_s = in_pc;
            A_SEL_ZERO:  a_s = {XLEN{1'b0}};
            A_SEL_ZERO3: a_s = {XLEN{1'b0}};
            default:     a_s = {XLEN{1'b0}};
        endcase
    end

    // Operand B mux: rs2, immediate, link increment, zero.
    always_comb begin
        b_s = {XLEN{1'b0}};
        case (in_b_sel)
            B_SEL_RS2:  b_s = rs2_fwd_s;
            B_SEL_IMM:  b_s = in_imm;
            B_SEL_LINK: b_s = LINK_INC;
            B_SEL_ZERO: b_s = {XLEN{1'b0}};
            default:    b_s = {XLEN{1'b0}};
        endcase
    end

    // Load-use hazard only matters for sources actually consumed; a load
    // result is not available from EX/MEM so the consumer must wait a cycle.
    always_comb begin
        hazard_s = 1'b0;
        if (in_valid && exm_wr_en && exm_is_load && (exm_rd != {RA_W{1'b0}})) begin
            hazard_s = ((exm_rd == in_rs1_addr) && (in_a_sel == A_SEL_RS1)) ||
                       ((exm_rd == in_rs2_addr) && in_uses_rs2);
        end else begin
            hazard_s = 1'b0;
        end
        ready_s   = (!out_valid_r || out_ready) && !hazard_s && !flush;
        capture_s = in_valid && ready_s;
    end

    // Output bundle register: flush wins, then capture, then drain on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_a_r     <= {XLEN{1'b0}};
            out_b_r     <= {XLEN{1'b0}};
            out_rs2_r   <= {XLEN{1'b0}};
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (capture_s) begin
            out_valid_r <= 1'b1;
            out_a_r     <= a_s;
            out_b_r     <= b_s;
            out_rs2_r   <= rs2_fwd_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating count of load-use stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hazard_cnt_r <= {CNT_W{1'b0}};
        end else if (hazard_s && !(&hazard_cnt_r)) begin
            hazard_cnt_r <= hazard_cnt_r + CNT_ONE;
        end else begin
            hazard_cnt_r <= hazard_cnt_r;
        end
    end

    assign in_ready   = ready_s;
    assign out_valid  = out_valid_r;
    assign out_a      = out_a_r;
    assign out_b      = out_b_r;
    assign out_rs2    = out_rs2_r;
    assign hazard_cnt = hazard_cnt_r;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage (built with CNT_W=4 so counter
// saturation is reachable quickly).
module tb_alu_operand_stage;

    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [RA_W-1:0]  in_rs1_addr;
    logic [RA_W-1:0]  in_rs2_addr;
    logic [XLEN-1:0]  in_rs1_data;
    logic [XLEN-1:0]  in_rs2_data;
    logic [XLEN-1:0]  in_imm;
    logic [1:0]       in_a_sel;
    logic [1:0]       in_b_sel;
    logic             in_uses_rs2;
    logic             exm_wr_en;
    logic             exm_is_load;
    logic [RA_W-1:0]  exm_rd;
    logic [XLEN-1:0]  exm_data;
    logic             wb_wr_en;
    logic [RA_W-1:0]  wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_a;
    logic [XLEN-1:0]  out_b;
    logic [XLEN-1:0]  out_rs2;
    logic [CNT_W-1:0] hazard_cnt;

    int errors = 0;
    int checks = 0;

    alu_operand_stage #(.XLEN(XLEN), .RA_W(RA_W), .INST_BYTES(4), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_rs1_addr (in_rs1_addr),
        .in_rs2_addr (in_rs2_addr),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .in_imm      (in_imm),
        .in_a_sel    (in_a_sel),
        .in_b_sel    (in_b_sel),
        .in_uses_rs2 (in_uses_rs2),
        .exm_wr_en   (exm_wr_en),
        .exm_is_load (exm_is_load),
        .exm_rd      (exm_rd),
        .exm_data    (exm_data),
        .wb_wr_en    (wb_wr_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_rs2     (out_rs2),
        .hazard_cnt  (hazard_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        in_valid    = 1'b0;
        in_pc       = 32'h0;
        in_rs1_addr = 5'd0;
        in_rs2_addr = 5'd0;
        in_rs1_data = 32'h0;
        in_rs2_data = 32'h0;
        in_imm      = 32'h0;
        in_a_sel    = 2'd0;
        in_b_sel    = 2'd0;
        in_uses_rs2 = 1'b0;
        exm_wr_en   = 1'b0;
        exm_is_load = 1'b0;
        exm_rd      = 5'd0;
        exm_data    = 32'h0;
        wb_wr_en    = 1'b0;
        wb_rd       = 5'd0;
        wb_data     = 32'h0;
        flush       = 1'b0;
        out_ready   = 1'b1;
    endtask

    // Drive a reset pulse spanning two edges; inputs are idle on release.
    task automatic apply_reset();
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Advance to just after the next active edge.
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_a !== 32'h0 || out_b !== 32'h0 || out_rs2 !== 32'h0 || hazard_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b a=%h b=%h rs2=%h cnt=%0d, want all zero", out_valid, out_a, out_b, out_rs2, hazard_cnt);
        end
        apply_reset();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_forwarding();
        apply_reset();
        // EX/MEM beats MEM/WB for the same register.
        in_valid = 1'b1; in_rs1_addr = 5'd5; in_rs1_data = 32'h1111;
        in_rs2_addr = 5'd6; in_rs2_data = 32'h2222; in_uses_rs2 = 1'b1;
        in_a_sel = 2'd0; in_b_sel = 2'd0;
        exm_wr_en = 1'b1; exm_rd = 5'd5; exm_data = 32'hAAAA;
        wb_wr_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hBBBB;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_a !== 32'hAAAA || out_b !== 32'h2222 || out_rs2 !== 32'h2222) begin
            errors++;
            $display("FAIL fwd_exm: valid=%b a=%h b=%h rs2=%h, want 1 aaaa 2222 2222", out_valid, out_a, out_b, out_rs2);
        end
        // Only MEM/WB matches; rs2 also takes it.
        exm_rd = 5'd9; in_rs2_addr = 5'd5;
        step();
        checks++;
        if (out_a !== 32'hBBBB || out_b !== 32'hBBBB || out_rs2 !== 32'hBBBB) begin
            errors++;
            $display("FAIL fwd_wb: a=%h b=%h rs2=%h, want bbbb bbbb bbbb", out_a, out_b, out_rs2);
        end
    endtask

    task automatic test_x0_and_sel();
        apply_reset();
        in_valid = 1'b1; in_rs1_addr = 5'd0; in_rs1_data = 32'h0;
        in_rs2_addr = 5'd0; in_rs2_data = 32'h0;
        exm_wr_en = 1'b1; exm_rd = 5'd0; exm_data = 32'h1234;
        wb_wr_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h5678;
        in_a_sel = 2'd0; in_b_sel = 2'd0;
        step();
        checks++;
        if (out_a !== 32'h0 || out_rs2 !== 32'h0) begin
            errors++;
            $display("FAIL x0_no_fwd: a=%h rs2=%h, want 0 0", out_a, out_rs2);
        end
        // jal: pc + link increment.
        exm_wr_en = 1'b0; wb_wr_en = 1'b0;
        in_pc = 32'h100; in_a_sel = 2'd1; in_b_sel = 2'd2;
        step();
        checks++;
        if (out_a !== 32'h100 || out_b !== 32'h4) begin
            errors++;
            $display("FAIL jal_ops: a=%h b=%h, want 100 4", out_a, out_b);
        end
        // lui: zero + immediate.
        in_a_sel = 2'd2; in_b_sel = 2'd1; in_imm = 32'hFFFFF800;
        step();
        checks++;
        if (out_a !== 32'h0 || out_b !== 32'hFFFFF800) begin
            errors++;
            $display("FAIL lui_ops: a=%h b=%h, want 0 fffff800", out_a, out_b);
        end
        // Select 3 on both sides yields zeros.
        in_a_sel = 2'd3; in_b_sel = 2'd3; in_pc = 32'h200;
        step();
        checks++;
        if (out_a !== 32'h0 || out_b !== 32'h0) begin
            errors++;
            $display("FAIL sel3_zero: a=%h b=%h, want 0 0", out_a, out_b);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        in_valid = 1'b1; in_rs1_addr = 5'd3; in_rs1_data = 32'h33;
        in_rs2_addr = 5'd7; in_rs2_data = 32'h99; in_uses_rs2 = 1'b1;
        in_a_sel = 2'd0; in_b_sel = 2'd0;
        exm_wr_en = 1'b1; exm_is_load = 1'b1; exm_rd = 5'd7; exm_data = 32'hDEAD;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_use_stall: in_ready=%b want 0", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || hazard_cnt !== 4'd1) begin
            errors++;
            $display("FAIL load_use_cnt: valid=%b cnt=%0d, want 0 1", out_valid, hazard_cnt);
        end
        // Load has moved to MEM/WB.
        exm_wr_en = 1'b0; exm_is_load = 1'b0;
        wb_wr_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_use_release: in_ready=%b want 1", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_rs2 !== 32'h55 || out_b !== 32'h55 || out_a !== 32'h33 || hazard_cnt !== 4'd1) begin
            errors++;
            $display("FAIL load_use_fwd: valid=%b a=%h b=%h rs2=%h cnt=%0d, want 1 33 55 55 1", out_valid, out_a, out_b, out_rs2, hazard_cnt);
        end
    endtask

    task automatic test_backpressure_flush();
        apply_reset();
        in_valid = 1'b1; in_rs1_addr = 5'd1; in_rs1_data = 32'h10;
        in_a_sel = 2'd0; in_b_sel = 2'd1; in_imm = 32'h20;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_a !== 32'h10 || out_b !== 32'h20) begin
            errors++;
            $display("FAIL bp_first: valid=%b a=%h b=%h, want 1 10 20", out_valid, out_a, out_b);
        end
        in_rs1_data = 32'h30; in_imm = 32'h40; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready_%0d: in_ready=%b want 0", i, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_a !== 32'h10 || out_b !== 32'h20) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%b a=%h b=%h, want 1 10 20", i, out_valid, out_a, out_b);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_a !== 32'h30 || out_b !== 32'h40) begin
            errors++;
            $display("FAIL bp_release: valid=%b a=%h b=%h, want 1 30 40", out_valid, out_a, out_b);
        end
        // Flush kills the capture that would otherwise happen.
        flush = 1'b1; in_rs1_data = 32'h50;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: in_ready=%b want 0", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: valid=%b want 0", out_valid);
        end
        flush = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_a !== 32'h50) begin
            errors++;
            $display("FAIL post_flush: valid=%b a=%h, want 1 50", out_valid, out_a);
        end
        // Reset during backpressure clears outputs asynchronously.
        out_ready = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_a !== 32'h0 || out_b !== 32'h0 || out_rs2 !== 32'h0 || hazard_cnt !== 4'd0) begin
            errors++;
            $display("FAIL bp_reset: valid=%b a=%h b=%h rs2=%h cnt=%0d, want all zero", out_valid, out_a, out_b, out_rs2, hazard_cnt);
        end
        step();
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_no_capture: valid=%b a=%h, want 0 0", out_valid, out_a);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        in_valid = 1'b1; in_rs1_addr = 5'd7; in_a_sel = 2'd0; in_b_sel = 2'd1;
        exm_wr_en = 1'b1; exm_is_load = 1'b1; exm_rd = 5'd7;
        for (int i = 0; i < 19; i++) begin
            step();
            if (i == 13) begin
                checks++;
                if (hazard_cnt !== 4'd14) begin
                    errors++;
                    $display("FAIL sat_pre: cnt=%0d want 14", hazard_cnt);
                end
            end
        end
        checks++;
        if (hazard_cnt !== 4'd15 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_hold: cnt=%0d valid=%b, want 15 0", hazard_cnt, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_x0_and_sel();
        test_load_use();
        test_backpressure_flush();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
